// File: rtl/m72_pkg.sv
// rtl/m72_pkg.sv - shared pixel type and palette bank bases for the M72 video path
package m72_pkg;

    localparam logic [8:0] PAL_SPR_BASE = 9'h000;
    localparam logic [8:0] PAL_BG_BASE  = 9'h100;

    typedef struct packed {
        logic [3:0] color;
        logic [3:0] index;
    } pix_t;

endpackage

// File: rtl/dpramv.sv
// rtl/dpramv.sv - dual-port RAM, port a read/write, port b read-only, synchronous reads
module dpramv #(
    parameter int widthad_a = 9,
    parameter int width_a   = 8
) (
    input  logic                 clock_a,
    input  logic                 wren_a,
    input  logic [widthad_a-1:0] address_a,
    input  logic [width_a-1:0]   data_a,
    output logic [width_a-1:0]   q_a,
    input  logic                 clock_b,
    input  logic [widthad_a-1:0] address_b,
    output logic [width_a-1:0]   q_b
);

    logic [width_a-1:0] mem [0:(1<<widthad_a)-1];

    // Read-before-write on both ports: a same-cycle write is only visible on the next read.
    always_ff @(posedge clock_a) begin
        if (wren_a) begin
            mem[address_a] <= data_a;
        end
        q_a <= mem[address_a];
    end

    always_ff @(posedge clock_b) begin
        q_b <= mem[address_b];
    end

endmodule

// File: rtl/layer_mixer.sv
// rtl/layer_mixer.sv - sprite/BG priority mix, palette lookup and blank-matched RGB out
module layer_mixer
    import m72_pkg::*;
#(
    parameter int          PAL_AW    = 9,
    parameter logic [14:0] BLANK_RGB = 15'h0000
) (
    input  logic        CLK_32M,
    input  logic        RESET_N,
    input  logic        CE_PIX,
    input  logic        HBLK,
    input  logic        VBLK,
    input  logic [7:0]  SPR_PIX,
    input  logic [7:0]  BGA_PIX,
    input  logic        BGA_PRIO,
    input  logic [7:0]  BGB_PIX,
    input  logic [2:0]  LAYER_EN,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    output logic        DOUT_VALID,
    input  logic [19:0] A,
    input  logic [1:0]  BYTE_SEL,
    input  logic        PAL_CS,
    input  logic        MRD,
    input  logic        MWR,
    output logic [4:0]  R,
    output logic [4:0]  G,
    output logic [4:0]  B,
    output logic        HBLK_O,
    output logic        VBLK_O
);

    function automatic logic [8:0] mix_select(input pix_t spr, input pix_t bga, input logic bga_prio,
                                              input pix_t bgb, input logic [2:0] en);
        logic spr_op;
        logic bga_op;
        spr_op = en[0] && (spr.index != 4'h0);
        bga_op = en[1] && (bga.index != 4'h0);
        if (bga_op && bga_prio)  return PAL_BG_BASE  | {1'b0, bga};
        else if (spr_op)         return PAL_SPR_BASE | {1'b0, spr};
        else if (bga_op)         return PAL_BG_BASE  | {1'b0, bga};
        else if (en[2])          return PAL_BG_BASE  | {1'b0, bgb};
        else                     return PAL_BG_BASE;
    endfunction

    logic [PAL_AW-1:0] cpu_entry;
    logic [PAL_AW-1:0] addr1;
    logic              hblk1;
    logic              vblk1;
    logic [7:0]        qa_lo;
    logic [6:0]        qa_hi;
    logic [7:0]        qb_lo;
    logic [6:0]        qb_hi;
    logic [14:0]       rgb;
    logic              rd_valid;
    logic              wr_en;
    logic              unused_bits;

    assign cpu_entry   = A[PAL_AW:1];
    assign wr_en       = PAL_CS & MWR;
    assign unused_bits = &{1'b0, A[19:PAL_AW+1], A[0], DIN[15]};

    dpramv #(.widthad_a(PAL_AW), .width_a(8)) u_pal_lo (
        .clock_a   (CLK_32M),
        .wren_a    (wr_en & BYTE_SEL[0]),
        .address_a (cpu_entry),
        .data_a    (DIN[7:0]),
        .q_a       (qa_lo),
        .clock_b   (CLK_32M),
        .address_b (addr1),
        .q_b       (qb_lo)
    );

    dpramv #(.widthad_a(PAL_AW), .width_a(7)) u_pal_hi (
        .clock_a   (CLK_32M),
        .wren_a    (wr_en & BYTE_SEL[1]),
        .address_a (cpu_entry),
        .data_a    (DIN[14:8]),
        .q_a       (qa_hi),
        .clock_b   (CLK_32M),
        .address_b (addr1),
        .q_b       (qb_hi)
    );

    // Stage-1 blank regs reset high so the first post-reset CE_PIX still shows blank.
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            addr1  <= '0;
            hblk1  <= 1'b1;
            vblk1  <= 1'b1;
            rgb    <= 15'h0000;
            HBLK_O <= 1'b1;
            VBLK_O <= 1'b1;
        end else if (CE_PIX) begin
            addr1  <= PAL_AW'(mix_select(SPR_PIX, BGA_PIX, BGA_PRIO, BGB_PIX, LAYER_EN));
            hblk1  <= HBLK;
            vblk1  <= VBLK;
            rgb    <= (hblk1 | vblk1) ? BLANK_RGB : {qb_hi, qb_lo};
            HBLK_O <= hblk1;
            VBLK_O <= vblk1;
        end
    end

    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= PAL_CS & MRD;
        end
    end

    assign R          = rgb[4:0];
    assign G          = rgb[9:5];
    assign B          = rgb[14:10];
    assign DOUT       = rd_valid ? {1'b0, qa_hi, qa_lo} : 16'h0000;
    assign DOUT_VALID = rd_valid;

endmodule
